// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the stage wrappers.
// Holds the controller state encoding, the $zero register index and the control bundle.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_flush;
    logic pipe_hold;
  } hazard_ctrl_t;

  // Canned control patterns, one per priority level.
  localparam hazard_ctrl_t CTRL_IDLE = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
    id_ex_bubble: 1'b0, ex_mem_flush: 1'b0, pipe_hold: 1'b0
  };

  localparam hazard_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
    id_ex_bubble: 1'b0, ex_mem_flush: 1'b0, pipe_hold: 1'b1
  };

  localparam hazard_ctrl_t CTRL_FLUSH = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
    id_ex_bubble: 1'b1, ex_mem_flush: 1'b1, pipe_hold: 1'b0
  };

  localparam hazard_ctrl_t CTRL_STALL = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
    id_ex_bubble: 1'b1, ex_mem_flush: 1'b0, pipe_hold: 1'b0
  };

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
// Increment is visible the cycle after inc is sampled high.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline with a data-memory watchdog.
// Controls are combinational from state and inputs; state, watchdog and counters are registered.
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_pcsrc,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  ctrl_state_t  state_q, state_d;
  logic [15:0]  wait_cnt_q, wait_cnt_d;
  logic         mem_timeout_q, mem_timeout_d;
  logic         mem_wait;
  logic         load_use;
  hazard_ctrl_t ctrl;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = ex_mem_read & (ex_rt != REG_ZERO) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // A branch flush wins over load-use: the stalled instruction is being squashed anyway.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (reset) begin
      if (state_q == ERROR) begin
        ctrl = CTRL_FREEZE;
      end else if (mem_wait) begin
        ctrl = CTRL_FREEZE;
      end else if (mem_pcsrc) begin
        ctrl = CTRL_FLUSH;
      end else if (load_use) begin
        ctrl = CTRL_STALL;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = 16'd0;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN, WAIT_MEM: begin
        if (mem_wait) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            state_d    = WAIT_MEM;
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      ERROR: begin
        state_d       = ERROR;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (~ctrl.pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (ctrl.if_id_flush),
    .count (flush_count)
  );

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign pipe_hold    = ctrl.pipe_hold;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a rule-level model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_hazard_controller;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, mem_pcsrc, dmem_req, dmem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .mem_pcsrc    (mem_pcsrc),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_flush (ex_mem_flush),
    .pipe_hold    (pipe_hold),
    .mem_timeout  (mem_timeout),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  // Model state: error flag, consecutive-wait run length, and the two event tallies.
  bit m_err = 1'b0;
  int m_wc  = 0;
  int m_sc  = 0;
  int m_fc  = 0;
  logic [5:0] m_ctrl;

  // Returns {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold}.
  function automatic logic [5:0] rule_ctrl(input bit rst_n, input bit err, input bit req, input bit rdy,
                                           input bit br, input bit mr, input int ert, input int rs,
                                           input int rt, input bit urt);
    bit hazard;
    hazard = mr && ert != 0 && (ert == rs || (urt && ert == rt));
    if (!rst_n)          return 6'b110000;
    if (err)             return 6'b000001;
    if (req && !rdy)     return 6'b000001;
    if (br)              return 6'b111110;
    if (hazard)          return 6'b000100;
    return 6'b110000;
  endfunction

  always_comb m_ctrl = rule_ctrl(reset, m_err, dmem_req, dmem_ready, mem_pcsrc, ex_mem_read,
                                 int'(ex_rt), int'(id_rs), int'(id_rt), id_uses_rt);

  always @(posedge clk) begin
    if (!reset) begin
      m_err <= 1'b0;
      m_wc  <= 0;
      m_sc  <= 0;
      m_fc  <= 0;
    end else begin
      if (!m_ctrl[5]) m_sc <= (m_sc >= SAT) ? SAT : m_sc + 1;
      if (m_ctrl[3])  m_fc <= (m_fc >= SAT) ? SAT : m_fc + 1;
      if (!m_err) begin
        if (dmem_req && !dmem_ready) begin
          m_wc <= m_wc + 1;
          if (m_wc + 1 == TIMEOUT) m_err <= 1'b1;
        end else begin
          m_wc <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_model",
            {17'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold,
             mem_timeout, stall_count, flush_count},
            {17'd0, m_ctrl, m_err, 4'(m_sc), 4'(m_fc)});
    end
  end

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic mr,
                       input logic [4:0] ert, input logic br, input logic req, input logic rdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr; ex_rt = ert;
    mem_pcsrc = br; dmem_req = req; dmem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick(2);
    chk_en = 1'b1;
    check("reset_stall_count", 32'(stall_count), 32'd0);
    check("reset_mem_timeout", 32'(mem_timeout), 32'd0);

    // Load-use inputs while reset is low must still give idle controls.
    drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    check("reset_forces_idle", 32'({pc_write, id_ex_bubble}), 32'b10);
    tick(1);

    reset = 1'b1;
    drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    check("load_use_stall", 32'({pc_write, if_id_write, id_ex_bubble}), 32'b001);
    tick(1);
    idle();
    check("load_use_release", 32'({pc_write, if_id_write, id_ex_bubble}), 32'b110);
    check("load_use_count", 32'(stall_count), 32'd1);

    drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    check("rt_unused_no_stall", 32'(pc_write), 32'd1);
    drive(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    check("rt_used_stall", 32'(pc_write), 32'd0);
    tick(1);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("zero_reg_no_stall", 32'(pc_write), 32'd1);
    tick(1);

    // Branch resolving together with a load-use: flush wins.
    do_reset();
    drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    check("branch_flush",
          32'({pc_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold}), 32'b11110);
    tick(1);
    idle();
    check("branch_flush_count", 32'(flush_count), 32'd1);
    check("branch_stall_count", 32'(stall_count), 32'd0);

    // Three-cycle memory wait then release.
    do_reset();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("mem_wait_hold", 32'({pc_write, pipe_hold}), 32'b01);
    tick(3);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("mem_ready_release", 32'({pc_write, pipe_hold}), 32'b10);
    tick(1);
    idle();
    check("mem_wait_stall_count", 32'(stall_count), 32'd3);
    check("mem_wait_no_timeout", 32'(mem_timeout), 32'd0);

    // Branch seen during a wait is deferred to the ready cycle.
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("branch_in_wait", 32'({if_id_flush, pipe_hold}), 32'b01);
    tick(1);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    check("branch_at_ready", 32'({if_id_flush, pipe_hold}), 32'b10);
    tick(1);

    // Dropping dmem_req clears the wait run; two short runs never time out.
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick(2);
    idle();
    tick(1);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick(3);
    check("req_drop_clears_wait", 32'(mem_timeout), 32'd0);
    idle();
    tick(1);

    // Watchdog: four consecutive wait edges trip ERROR.
    do_reset();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick(3);
    check("watchdog_before", 32'(mem_timeout), 32'd0);
    tick(1);
    check("watchdog_trip", 32'(mem_timeout), 32'd1);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick(1);
    check("error_sticky", 32'({mem_timeout, pipe_hold, pc_write}), 32'b110);
    reset = 1'b0;
    tick(1);
    check("error_cleared", 32'(mem_timeout), 32'd0);
    reset = 1'b1;
    idle();
    tick(1);

    // Saturation of the 4-bit stall counter.
    do_reset();
    drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    tick(20);
    check("stall_saturate", 32'(stall_count), 32'd15);
    idle();
    tick(2);
    check("stall_saturate_hold", 32'(stall_count), 32'd15);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central stall/flush/freeze sequencer for the 5-stage MIPS pipeline. It sits beside the datapath stages, watches the IF/ID, ID/EX and EX/MEM pipeline registers plus the data-memory handshake, and drives the write-enable, bubble, flush and hold controls those stages obey. It also owns a data-memory wait watchdog and saturating stall/flush performance counters.

## Interface
- TIMEOUT, 255: consecutive not-ready data-memory cycles tolerated before the block enters ERROR; legal range 1..65535.
- CNT_W, 16: width of the performance counters.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- id_rs  in  5  rs field of the IF/ID instruction.
- id_rt  in  5  rt field of the IF/ID instruction.
- id_uses_rt  in  1  IF/ID instruction reads rt as a source (R-type, beq, sw).
- ex_mem_read  in  1  MemRead bit of the ID/EX M control field.
- ex_rt  in  5  rt (load destination) held in ID/EX.
- mem_pcsrc  in  1  taken branch resolved in MEM this cycle.
- dmem_req  in  1  MEM stage is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_bubble  out  1  zero the control bits written into ID/EX.
- ex_mem_flush  out  1  zero the control bits written into EX/MEM.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB, and gate the register-file write.
- mem_timeout  out  1  sticky watchdog error.
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_count  out  CNT_W  saturating count of cycles with a branch flush applied.

## Operation
- **FSM states:**
  - RUN: normal operation.
  - WAIT_MEM: data-memory wait in progress.
  - ERROR: terminal until reset.
- **Hazard terms:**
  - mem_wait = dmem_req & !dmem_ready.
  - load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- **Priority, highest first:** ERROR, mem_wait, mem_pcsrc, load_use, idle.
  - ERROR: pc_write=0, if_id_write=0, pipe_hold=1, flushes=0, mem_timeout=1.
  - mem_wait: pc_write=0, if_id_write=0, pipe_hold=1, all flush/bubble=0.
  - mem_pcsrc: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1. A simultaneous load_use is discarded because the stalled instruction is flushed.
  - load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_hold=0.
  - idle: pc_write=1, if_id_write=1, all others 0.
- **Transitions:**
  - RUN→WAIT_MEM on mem_wait.
  - WAIT_MEM→RUN on dmem_ready. Normal priority rules apply in that release cycle.
  - RUN/WAIT_MEM→ERROR when mem_wait has held for TIMEOUT consecutive cycles.
  - A dmem_req drop in WAIT_MEM returns to RUN and clears the wait count.
- **Watchdog:** wait_cnt (16 bit) increments on each mem_wait cycle and clears on any non-mem_wait cycle. When mem_wait=1 and wait_cnt==TIMEOUT-1, the next state is ERROR.
- **Counters:** stall_count and flush_count hold at all-ones once saturated; no wrap.

## Timing
- Control outputs are combinational from state and inputs, with zero-cycle latency.
- FSM state, wait_cnt, mem_timeout and the counters are registered. Counter increments are visible the cycle after the event.
- While reset=0 at an edge, the following take effect after that edge: state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0, flush_count=0.
- While reset is held low, control outputs are forced to idle values (pc_write=1, if_id_write=1, rest 0) regardless of inputs.
- Reset asserted mid-wait or in ERROR returns to RUN on the next edge. No pending wait is remembered.
- mem_pcsrc and dmem_req are mutually exclusive by construction. If both are seen anyway, mem_wait wins and the branch flush is applied in the dmem_ready cycle.

## Structure
- Shared package pipeline_ctrl_pkg contains:
  - ctrl_state_t enum (RUN, WAIT_MEM, ERROR).
  - REG_ZERO constant (5'd0).
  - hazard_ctrl_t struct bundling the six control outputs, also used by the stage wrappers.
- One sub-module, sat_counter #(W): synchronous active-low clear, inc enable, saturates at all-ones. Instantiated twice.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rt=8, id_rs=8 → that cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle with ex_mem_read=0: idle outputs and stall_count=1.
- **rt-only / $zero cases:**
  - ex_rt=9, id_rt=9, id_uses_rt=0 → no stall.
  - ex_rt=0, id_rs=0, ex_mem_read=1 → no stall.
- **Branch plus load-use same cycle:** mem_pcsrc=1 → if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1. Next cycle flush_count=1, stall_count=0.
- **Memory wait:** dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 → pipe_hold=1 for exactly 3 cycles, state returns to RUN, stall_count=3.
- **Watchdog:** TIMEOUT=4, dmem_req=1 with ready=0 held → mem_timeout=1 after the 4th edge. It stays set with ready=1, then clears one edge after reset=0.
- **Saturation:** CNT_W=4 with 20 load-use stall cycles → stall_count=15 and held there.
